// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: FSM states and port-select codes.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUSY_I = 3'd1,
        ST_BUSY_D = 3'd2,
        ST_RESP_I = 3'd3,
        ST_RESP_D = 3'd4
    } arb_state_t;

    typedef enum logic {
        SEL_I = 1'b0,
        SEL_D = 1'b1
    } arb_sel_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = core + memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  i_req;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  i_done;
    logic                  i_err;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_done;
    logic                  d_err;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arb_timeout_ctr.sv
// Watchdog counter for a pending memory request; o_expired flags the last allowed cycle.
module mem_arb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-fetch and D-load/store onto one memory port with an ack timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed D-over-I priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  io_bus,
    output logic               busy
);
    arb_state_t            r_state;
    logic                  r_busy;
    logic                  r_mem_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_i_done;
    logic                  r_i_err;
    logic [DATA_WIDTH-1:0] r_i_rdata;
    logic                  r_d_done;
    logic                  r_d_err;
    logic [DATA_WIDTH-1:0] r_d_rdata;

    logic     w_any_req;
    logic     w_in_busy;
    logic     w_expired;
    arb_sel_t w_sel;

    assign w_any_req = io_bus.i_req | io_bus.d_req;
    assign w_in_busy = (r_state == ST_BUSY_I) || (r_state == ST_BUSY_D);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_d;
    // On a tie the port that did not win last time goes first.
    assign w_sel = (io_bus.d_req && (!io_bus.i_req || !r_last_d)) ? SEL_D : SEL_I;
`else
    assign w_sel = io_bus.d_req ? SEL_D : SEL_I;
`endif

    mem_arb_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_in_busy),
        .i_en      (w_in_busy),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_done  <= 1'b0;
            r_i_err   <= 1'b0;
            r_i_rdata <= '0;
            r_d_done  <= 1'b0;
            r_d_err   <= 1'b0;
            r_d_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_d  <= 1'b0;
`endif
        end else begin
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_busy    <= 1'b1;
                        r_mem_req <= 1'b1;
                        if (w_sel == SEL_D) begin
                            r_state <= ST_BUSY_D;
                            r_we    <= io_bus.d_we;
                            r_addr  <= io_bus.d_addr;
                            r_wdata <= io_bus.d_wdata;
                        end else begin
                            r_state <= ST_BUSY_I;
                            r_we    <= 1'b0;
                            r_addr  <= io_bus.i_addr;
                            r_wdata <= '0;
                        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_d <= (w_sel == SEL_D);
`endif
                    end
                end
                ST_BUSY_I: begin
                    // An ack on the expiring cycle still wins over the timeout.
                    if (io_bus.mem_ack || w_expired) begin
                        r_state   <= ST_RESP_I;
                        r_mem_req <= 1'b0;
                        r_we      <= 1'b0;
                        r_i_done  <= 1'b1;
                        r_i_err   <= !io_bus.mem_ack;
                        r_i_rdata <= io_bus.mem_ack ? io_bus.mem_rdata : '0;
                    end
                end
                ST_BUSY_D: begin
                    if (io_bus.mem_ack || w_expired) begin
                        r_state   <= ST_RESP_D;
                        r_mem_req <= 1'b0;
                        r_we      <= 1'b0;
                        r_d_done  <= 1'b1;
                        r_d_err   <= !io_bus.mem_ack;
                        r_d_rdata <= (io_bus.mem_ack && !r_we) ? io_bus.mem_rdata : '0;
                    end
                end
                ST_RESP_I, ST_RESP_D: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_busy    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    assign busy             = r_busy;
    assign io_bus.mem_req   = r_mem_req;
    assign io_bus.mem_we    = r_we;
    assign io_bus.mem_addr  = r_addr;
    assign io_bus.mem_wdata = r_wdata;
    assign io_bus.i_done    = r_i_done;
    assign io_bus.i_err     = r_i_err;
    assign io_bus.i_rdata   = r_i_rdata;
    assign io_bus.d_done    = r_d_done;
    assign io_bus.d_err     = r_d_err;
    assign io_bus.d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus_if.slave),
        .busy   (busy)
    );

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    logic        m_last_d;   // model: 1 when the D-port won the most recent grant

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mreq"}, bus_if.mem_req, 0);
        chk({tag, "_done"}, {bus_if.i_done, bus_if.d_done}, 0);
    endtask

    // Called at the negedge of an IDLE cycle with the requests already driven.
    // ack_cyc: BUSY cycle (1-based) in which memory acks; 0 or >TO means never.
    task automatic run_txn(input int unsigned ack_cyc, input logic [DW-1:0] rd_val);
        logic          win_d;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [DW-1:0] e_rdata;
        logic          e_we;
        logic          e_err;
        if (bus_if.i_req && bus_if.d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            win_d = !m_last_d;
`else
            win_d = 1'b1;
`endif
        end else begin
            win_d = bus_if.d_req;
        end
        m_last_d = win_d;
        e_addr   = win_d ? bus_if.d_addr : bus_if.i_addr;
        e_we     = win_d ? bus_if.d_we : 1'b0;
        e_wdata  = bus_if.d_wdata;
        e_err    = 1'b1;
        e_rdata  = '0;
        bus_if.mem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        // requester inputs are free to change once accepted
        if (win_d) begin
            bus_if.d_addr  = $urandom;
            bus_if.d_wdata = $urandom;
            bus_if.d_we    = 1'($urandom_range(0, 1));
        end else begin
            bus_if.i_addr = $urandom;
        end
        for (int k = 1; k <= TO; k++) begin
            chk("busy_mreq", bus_if.mem_req, 1);
            chk("busy_addr", bus_if.mem_addr, e_addr);
            chk("busy_we", bus_if.mem_we, e_we);
            if (e_we) chk("busy_wdata", bus_if.mem_wdata, e_wdata);
            chk("busy_flag", busy, 1);
            chk("busy_nodone", {bus_if.i_done, bus_if.d_done}, 0);
            bus_if.mem_ack   = (k == ack_cyc);
            bus_if.mem_rdata = (k == ack_cyc) ? rd_val : DW'($urandom);
            if (k == ack_cyc) begin
                e_err   = 1'b0;
                e_rdata = e_we ? '0 : rd_val;
            end
            @(negedge clk);
            if (k == ack_cyc) break;
        end
        chk("resp_idone", bus_if.i_done, !win_d);
        chk("resp_ddone", bus_if.d_done, win_d);
        if (win_d) begin
            chk("resp_drdata", bus_if.d_rdata, e_rdata);
            chk("resp_derr", bus_if.d_err, e_err);
            bus_if.d_req = 1'b0;
        end else begin
            chk("resp_irdata", bus_if.i_rdata, e_rdata);
            chk("resp_ierr", bus_if.i_err, e_err);
            bus_if.i_req = 1'b0;
        end
        chk("resp_mreq", bus_if.mem_req, 0);
        bus_if.mem_ack   = 1'($urandom_range(0, 1));
        bus_if.mem_rdata = $urandom;
        @(negedge clk);
        chk_idle("post");
        bus_if.mem_ack = 1'b0;
    endtask

    task automatic raise_i();
        bus_if.i_req  = 1'b1;
        bus_if.i_addr = $urandom;
    endtask

    task automatic raise_d();
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'($urandom_range(0, 1));
        bus_if.d_addr  = $urandom;
        bus_if.d_wdata = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.i_req = 0; bus_if.i_addr = '0;
        bus_if.d_req = 0; bus_if.d_we = 0; bus_if.d_addr = '0; bus_if.d_wdata = '0;
        bus_if.mem_ack = 0; bus_if.mem_rdata = '0;
        m_last_d = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        chk("rst_outs", {bus_if.mem_we, bus_if.mem_addr, bus_if.i_err, bus_if.d_err}, 0);
        chk("rst_rdata", {bus_if.i_rdata, bus_if.d_rdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle");

        // single fetch, ack one cycle after mem_req rises
        bus_if.i_req = 1'b1; bus_if.i_addr = 32'h100;
        run_txn(2, 32'hDEADBEEF);

        // zero-wait store
        bus_if.d_req = 1'b1; bus_if.d_we = 1'b1;
        bus_if.d_addr = 32'h200; bus_if.d_wdata = 32'h12345678;
        run_txn(1, 32'hCAFEF00D);

        // simultaneous requests, then a fresh tie after the D-port won last
        raise_i(); raise_d();
        run_txn(1, $urandom);
        run_txn(3, $urandom);
        raise_d();
        run_txn(1, $urandom);
        raise_i(); raise_d();
        run_txn(2, $urandom);
        run_txn(1, $urandom);

        // timeout and ack on the very last BUSY cycle
        bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = $urandom;
        run_txn(0, 32'h55AA55AA);
        bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = $urandom;
        run_txn(TO, 32'hA5A5A5A5);

        // reset while in BUSY_D
        bus_if.d_req = 1'b1; bus_if.d_we = 1'b0; bus_if.d_addr = 32'h300;
        @(negedge clk);
        chk("rstmid_mreq", bus_if.mem_req, 1);
        @(negedge clk);
        rst = 1'b1; bus_if.d_req = 1'b0;
        @(negedge clk);
        chk_idle("rstmid");
        rst = 1'b0; m_last_d = 1'b0;
        @(negedge clk);
        chk_idle("rstmid2");
        bus_if.i_req = 1'b1; bus_if.i_addr = 32'h400;
        run_txn(3, 32'h0BADC0DE);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            if (!bus_if.i_req && $urandom_range(0, 2) != 0) raise_i();
            if (!bus_if.d_req && $urandom_range(0, 2) != 0) raise_d();
            if (bus_if.i_req || bus_if.d_req) begin
                run_txn($urandom_range(1, TO + 3), $urandom);
            end else begin
                bus_if.mem_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk_idle("rnd_idle");
                bus_if.mem_ack = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
